byte_deserializer: RTL and testbench
====================================

Name: byte_deserializer

Overview:
- Receive-side counterpart of the narrowing 4:1 mux datapath: takes a stream of LANE_WIDTH-bit beats and assembles them into LANES-lane words, e.g. Z80 8-bit bus bytes into 16-bit words for peripheral registers or DMA.
- Valid/ready handshake on both sides.
- `in_last` flushes a partial word, and `out_keep` marks which lanes are valid.
- Sits between the Z80 data-bus capture logic and wide consumers.

Parameters:
- LANE_WIDTH, 8, bits per input beat.
- LANES, 2, beats per output word; legal range 2..4.
- MSB_FIRST, 0, lane order. 0: first beat goes to lane 0 (bits LANE_WIDTH-1:0), little-endian as on the Z80. 1: first beat goes to lane LANES-1.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input beat present.
- in_ready  output  1  block accepts a beat this cycle.
- in_data  input  LANE_WIDTH  input beat.
- in_last  input  1  beat ends the current word; a partial word is flushed.
- out_valid  output  1  assembled word present.
- out_ready  input  1  downstream accepts the word.
- out_data  output  LANE_WIDTH*LANES  assembled word.
- out_keep  output  LANES  per-lane valid mask, bit i matches lane i.
- out_last  output  1  word was closed by in_last.

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset state:
  - out_valid=0, out_data=0, out_keep=0, out_last=0.
  - Lane count=0, assembly register=0, assembly keep=0.
  - in_ready=1 in the cycle after reset deasserts.
  - While rst=1, all inputs are ignored and the reset values are forced.
- Handshake terms:
  - Input accept: `in_valid & in_ready`.
  - Output transfer: `out_valid & out_ready`.
  - `in_ready = ~out_valid | out_ready`. It is combinational, never depends on `in_valid` or `in_last`, and gives full 1-beat/cycle throughput when downstream is always ready.
- Lane index:
  - The write lane is `count` when MSB_FIRST=0, and `LANES-1-count` when MSB_FIRST=1.
  - The count register width is clog2(LANES), with a minimum of 1.
- Non-completing accept (`count < LANES-1` and `in_last=0`):
  - Write `in_data` into the lane of the assembly register and set its keep bit.
  - count <= count+1.
- Completing accept (`count = LANES-1` or `in_last=1`):
  - out_data <= assembly with this beat merged.
  - out_keep <= assembly keep merged with this lane's bit.
  - out_last <= in_last; out_valid <= 1.
  - Clear the assembly register and keep to 0; count <= 0.
- Word latency: out_valid rises 1 cycle after the completing accept.
- Lanes not written in a partial word: out_data bits are 0 and their keep bits are 0.
- Simultaneous output transfer and completing accept in one cycle: the new word replaces the old; out_valid stays 1 with no bubble.
- Output transfer with no completing accept: out_valid <= 0 next cycle. out_data, out_keep and out_last keep their values but are don't-care.
- Output stability: while `out_valid & ~out_ready`, out_data, out_keep and out_last hold stable and in_ready=0.
- in_last on a full-width beat (`count = LANES-1`) gives out_keep all ones and out_last=1.
- in_last on the first beat gives exactly one keep bit.
- Reset mid-word: partial assembly and any pending word are discarded with no output; the next accepted beat goes to lane index 0 (or LANES-1 when MSB_FIRST=1).
- in_valid=0: no state change apart from the output transfer above. in_data and in_last are ignored.
- No state machine beyond the count: FILL is count<LANES-1, LAST is count=LANES-1, and the output register acts as a 1-entry holding stage.

Decomposition:
- Shared package:
  - clog2 helper function.
  - Constant for the maximum LANES (4).
  - Lane-order enum: LSB_FIRST=0, MSB_FIRST=1.
- No sub-module warranted. Lane write-enable decode is a local generate loop; the team's existing demux2 is not reused because the lanes need registered enables.

Test Plan:
- Full words: defaults, out_ready=1; send beats 0x34, 0x12 -> out_data=0x1234, out_keep=2'b11, out_last=0; out_valid high 1 cycle after the second accept.
- Backpressure: 4 beats 0xA1..0xA4, out_ready=0 for 5 cycles after the first word.
  - Required: word 0xA2A1 held stable and in_ready=0 for those cycles.
  - Required: then 0xA4A3 with no beat lost or duplicated.
- Partial flush: LANES=4; beats 0x11, 0x22 (in_last=1) -> out_data=0x00002211, out_keep=4'b0011, out_last=1.
  - Required: the next beat 0x33 lands in lane 0.
- Reset mid-word: send beat 0x55, then pulse rst for 1 cycle, then beats 0x66, 0x77 -> a single word 0x7766 and no word containing 0x55.
- Throughput and order: 100 random beats, valid and ready both always 1 -> 50 words, one per 2 cycles, in order.
  - Required: repeat with MSB_FIRST=1; beats 0x12, 0x34 give 0x1234.
- Random stall: random in_valid and out_ready; a scoreboard compares against a reference model.
  - Required: no in_ready high while `out_valid & ~out_ready`.

Source files
------------

// File: rtl/byte_deserializer_pkg.sv
// Shared definitions for the byte deserializer: lane-order encoding,
// the supported lane range and a constant clog2 helper.
package byte_deserializer_pkg;

  localparam int MAX_LANES = 4;

  typedef enum logic {
    LSB_FIRST = 1'b0,
    MSB_FIRST = 1'b1
  } lane_order_e;

  // Width of a counter that spans 0..value-1, never narrower than one bit.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/byte_deserializer.sv
// Assembles LANE_WIDTH-bit beats into LANES-lane words with valid/ready on
// both sides; in_last flushes a partial word and out_keep flags live lanes.
module byte_deserializer
  import byte_deserializer_pkg::MAX_LANES, byte_deserializer_pkg::lane_order_e,
         byte_deserializer_pkg::clog2;
#(
  parameter int LANE_WIDTH = 8,
  parameter int LANES      = 2,
  parameter bit MSB_FIRST  = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANE_WIDTH-1:0]       in_data,
  input  logic                        in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANE_WIDTH*LANES-1:0] out_data,
  output logic [LANES-1:0]            out_keep,
  output logic                        out_last
);

  localparam int            CW         = clog2(LANES);
  localparam lane_order_e   ORDER      = lane_order_e'(MSB_FIRST);
  localparam logic [CW-1:0] LAST_COUNT = CW'(LANES - 1);

  if (LANES < 2 || LANES > MAX_LANES) begin : g_bad_lanes
    $error("byte_deserializer: LANES must be in 2..%0d", MAX_LANES);
  end

  logic [CW-1:0]               count;
  logic [CW-1:0]               lane_idx;
  logic [LANE_WIDTH*LANES-1:0] asm_data;
  logic [LANE_WIDTH*LANES-1:0] merged_data;
  logic [LANES-1:0]            asm_keep;
  logic [LANES-1:0]            lane_sel;
  logic [LANES-1:0]            merged_keep;
  logic                        accept;
  logic                        complete;
  logic                        out_take;

  // The output register is a 1-entry holding stage: it may refill in the
  // same cycle it drains, so throughput stays at one beat per cycle.
  assign in_ready = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready;
  assign complete = accept & ((count == LAST_COUNT) | in_last);
  assign out_take = out_valid & out_ready;

  assign lane_idx = (ORDER == byte_deserializer_pkg::MSB_FIRST) ? LAST_COUNT - count
                                                                 : count;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign lane_sel[i] = (lane_idx == CW'(i));
    assign merged_data[i*LANE_WIDTH +: LANE_WIDTH] =
      lane_sel[i] ? in_data : asm_data[i*LANE_WIDTH +: LANE_WIDTH];
  end

  assign merged_keep = asm_keep | lane_sel;

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values; later assignments to out_valid deliberately win.
  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      asm_data  <= '0;
      asm_keep  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_keep  <= '0;
      out_last  <= 1'b0;
    end else begin
      if (out_take) begin
        out_valid <= 1'b0;
      end

      if (complete) begin
        out_data  <= merged_data;
        out_keep  <= merged_keep;
        out_last  <= in_last;
        out_valid <= 1'b1;
        asm_data  <= '0;
        asm_keep  <= '0;
        count     <= '0;
      end else if (accept) begin
        asm_data  <= merged_data;
        asm_keep  <= merged_keep;
        count     <= count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_byte_deserializer.sv
// Self-checking bench for byte_deserializer: three configurations share one
// stimulus port set and are checked against a beat-grouping reference model.
module tb_byte_deserializer;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } word_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       out_ready;
  int         sel;          // 0: LANES=2 LSB, 1: LANES=4 LSB, 2: LANES=2 MSB

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last;
  logic [15:0] a_out_data;
  logic [1:0]  a_out_keep;
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last;
  logic [31:0] b_out_data;
  logic [3:0]  b_out_keep;
  logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_last;
  logic [15:0] c_out_data;
  logic [1:0]  c_out_keep;

  assign a_in_valid  = in_valid && (sel == 0);
  assign b_in_valid  = in_valid && (sel == 1);
  assign c_in_valid  = in_valid && (sel == 2);
  assign a_out_ready = (sel == 0) ? out_ready : 1'b1;
  assign b_out_ready = (sel == 1) ? out_ready : 1'b1;
  assign c_out_ready = (sel == 2) ? out_ready : 1'b1;

  byte_deserializer #(.LANE_WIDTH(8), .LANES(2), .MSB_FIRST(1'b0)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_data(a_out_data), .out_keep(a_out_keep),
    .out_last(a_out_last));

  byte_deserializer #(.LANE_WIDTH(8), .LANES(4), .MSB_FIRST(1'b0)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_data(b_out_data), .out_keep(b_out_keep),
    .out_last(b_out_last));

  byte_deserializer #(.LANE_WIDTH(8), .LANES(2), .MSB_FIRST(1'b1)) u_dut_c (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(c_out_valid),
    .out_ready(c_out_ready), .out_data(c_out_data), .out_keep(c_out_keep),
    .out_last(c_out_last));

  logic        m_in_ready, m_out_valid, m_out_last;
  logic [31:0] m_out_data;
  logic [3:0]  m_out_keep;

  always_comb begin
    m_in_ready  = a_in_ready;
    m_out_valid = a_out_valid;
    m_out_last  = a_out_last;
    m_out_data  = 32'(a_out_data);
    m_out_keep  = 4'(a_out_keep);
    if (sel == 1) begin
      m_in_ready  = b_in_ready;
      m_out_valid = b_out_valid;
      m_out_last  = b_out_last;
      m_out_data  = b_out_data;
      m_out_keep  = b_out_keep;
    end else if (sel == 2) begin
      m_in_ready  = c_in_ready;
      m_out_valid = c_out_valid;
      m_out_last  = c_out_last;
      m_out_data  = 32'(c_out_data);
      m_out_keep  = 4'(c_out_keep);
    end
  end

  int         n_cmp = 0;
  int         n_err = 0;
  int         words_seen = 0;
  logic       acc_seen;
  logic       hold_valid = 1'b0;
  word_t      hold_word;
  logic [7:0] part[$];
  word_t      exp_q[$];

  // Reference model and protocol checks, evaluated once per cycle mid-period.
  task automatic observe();
    word_t cur, exp;
    int    lanes, lane;
    bit    msb;
    lanes    = (sel == 1) ? 4 : 2;
    msb      = (sel == 2);
    cur      = {m_out_data, m_out_keep, m_out_last};
    acc_seen = in_valid && m_in_ready;
    if (rst) begin
      part.delete();
      exp_q.delete();
      hold_valid = 1'b0;
      acc_seen   = 1'b0;
      return;
    end

    n_cmp++;
    if (m_in_ready !== (!m_out_valid || out_ready)) begin
      n_err++;
      $display("FAIL in_ready_rule sel=%0d got %b want %b", sel, m_in_ready,
               !m_out_valid || out_ready);
    end

    if (hold_valid && m_out_valid) begin
      n_cmp++;
      if (cur !== hold_word) begin
        n_err++;
        $display("FAIL stall_stable sel=%0d got %h want %h", sel, cur, hold_word);
      end
    end
    hold_valid = m_out_valid && !out_ready;
    hold_word  = cur;

    if (m_out_valid && out_ready) begin
      words_seen++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_word sel=%0d got %h want none", sel, cur);
      end else begin
        exp = exp_q.pop_front();
        if (cur !== exp) begin
          n_err++;
          $display("FAIL word sel=%0d got data=%h keep=%b last=%b want data=%h keep=%b last=%b",
                   sel, cur.data, cur.keep, cur.last, exp.data, exp.keep, exp.last);
        end
      end
    end

    if (acc_seen) begin
      part.push_back(in_data);
      if (part.size() == lanes || in_last) begin
        exp = '0;
        exp.last = in_last;
        foreach (part[k]) begin
          lane = msb ? lanes - 1 - k : k;
          exp.data = exp.data | (32'(part[k]) << (8 * lane));
          exp.keep[lane] = 1'b1;
        end
        exp_q.push_back(exp);
        part.delete();
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [7:0] d, input logic last);
    int tries;
    tries    = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    do begin
      step();
      tries++;
    end while (!acc_seen && tries < 200);
    if (!acc_seen) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout sel=%0d got no accept want accept within 200 cycles", sel);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (n) step();
  endtask

  task automatic reset_dut();
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    rst       = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic check_word(input string name, input logic [31:0] d,
                            input logic [3:0] k, input logic l);
    n_cmp++;
    if ({m_out_valid, m_out_data, m_out_keep, m_out_last} !== {1'b1, d, k, l}) begin
      n_err++;
      $display("FAIL %s got v=%b data=%h keep=%b last=%b want v=1 data=%h keep=%b last=%b",
               name, m_out_valid, m_out_data, m_out_keep, m_out_last, d, k, l);
    end
  endtask

  task automatic test_reset();
    sel       = 0;
    out_ready = 1'b1;
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'hFF;
    in_last   = 1'b1;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      step();
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      n_cmp++;
      if ({m_out_valid, m_out_data, m_out_keep, m_out_last, m_in_ready} !== {1'b0, 32'h0, 4'h0, 1'b0, 1'b1}) begin
        n_err++;
        $display("FAIL reset_state sel=%0d got v=%b data=%h keep=%b last=%b rdy=%b want v=0 data=0 keep=0 last=0 rdy=1",
                 s, m_out_valid, m_out_data, m_out_keep, m_out_last, m_in_ready);
      end
    end
    sel = 0;
  endtask

  task automatic test_full_words();
    sel = 0;
    reset_dut();
    send_beat(8'h34, 1'b0);
    n_cmp++;
    if (m_out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL full_early_valid got %b want 0", m_out_valid);
    end
    send_beat(8'h12, 1'b0);
    check_word("full_word", 32'h1234, 4'b0011, 1'b0);
    idle(1);
    n_cmp++;
    if (m_out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL full_valid_drop got %b want 0", m_out_valid);
    end
  endtask

  task automatic test_backpressure();
    int w0;
    sel = 0;
    reset_dut();
    w0 = words_seen;
    send_beat(8'hA1, 1'b0);
    send_beat(8'hA2, 1'b0);
    out_ready = 1'b0;
    in_data   = 8'hA3;
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++;
      if ({m_in_ready, m_out_valid, m_out_data} !== {1'b0, 1'b1, 32'hA2A1}) begin
        n_err++;
        $display("FAIL backpressure_hold cycle=%0d got rdy=%b v=%b data=%h want rdy=0 v=1 data=a2a1",
                 i, m_in_ready, m_out_valid, m_out_data);
      end
    end
    out_ready = 1'b1;
    send_beat(8'hA3, 1'b0);
    send_beat(8'hA4, 1'b0);
    check_word("backpressure_second", 32'hA4A3, 4'b0011, 1'b0);
    idle(3);
    n_cmp++;
    if (words_seen - w0 != 2 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL backpressure_count got %0d words, %0d pending want 2 words, 0 pending",
               words_seen - w0, exp_q.size());
    end
  endtask

  task automatic test_partial_flush();
    sel = 1;
    reset_dut();
    send_beat(8'h11, 1'b0);
    send_beat(8'h22, 1'b1);
    check_word("partial_flush", 32'h00002211, 4'b0011, 1'b1);
    send_beat(8'h33, 1'b1);
    check_word("first_beat_last", 32'h00000033, 4'b0001, 1'b1);
    send_beat(8'h44, 1'b0);
    send_beat(8'h55, 1'b0);
    send_beat(8'h66, 1'b0);
    send_beat(8'h77, 1'b1);
    check_word("full_width_last", 32'h77665544, 4'b1111, 1'b1);
    idle(2);
  endtask

  task automatic test_reset_mid_word();
    int w0;
    sel = 0;
    reset_dut();
    w0 = words_seen;
    send_beat(8'h55, 1'b0);
    in_valid = 1'b0;
    rst      = 1'b1;
    step();
    rst = 1'b0;
    send_beat(8'h66, 1'b0);
    send_beat(8'h77, 1'b0);
    check_word("reset_mid_word", 32'h7766, 4'b0011, 1'b0);
    idle(2);
    n_cmp++;
    if (words_seen - w0 != 1) begin
      n_err++;
      $display("FAIL reset_mid_count got %0d want 1", words_seen - w0);
    end
  endtask

  task automatic test_throughput(input int s);
    int          w0;
    int unsigned c0;
    sel = s;
    reset_dut();
    w0 = words_seen;
    c0 = cyc;
    for (int i = 0; i < 100; i++) send_beat(8'($urandom), 1'b0);
    n_cmp++;
    if (cyc - c0 != 100) begin
      n_err++;
      $display("FAIL throughput_cycles sel=%0d got %0d want 100", s, cyc - c0);
    end
    idle(2);
    n_cmp++;
    if (words_seen - w0 != 50 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL throughput_words sel=%0d got %0d words, %0d pending want 50, 0",
               s, words_seen - w0, exp_q.size());
    end
    if (s == 2) begin
      send_beat(8'h12, 1'b0);
      send_beat(8'h34, 1'b0);
      check_word("msb_first_order", 32'h1234, 4'b0011, 1'b0);
      idle(2);
    end
  endtask

  task automatic test_random_stall(input int s);
    int w0;
    sel = s;
    reset_dut();
    w0 = words_seen;
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom);
      in_last   = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    out_ready = 1'b1;
    send_beat(8'h5A, 1'b1);
    idle(3);
    n_cmp++;
    if (exp_q.size() != 0 || part.size() != 0 || words_seen == w0) begin
      n_err++;
      $display("FAIL random_drain sel=%0d got %0d pending, %0d partial, %0d words want 0, 0, >0",
               s, exp_q.size(), part.size(), words_seen - w0);
    end
  endtask

  initial begin
    sel       = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_full_words();
    test_backpressure();
    test_partial_flush();
    test_reset_mid_word();
    test_throughput(0);
    test_throughput(2);
    for (int s = 0; s < 3; s++) test_random_stall(s);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
